// File: rtl/systolic_feed_ctrl_pkg.sv
// ============================================================================
// systolic_pkg
// Shared array geometry, controller state encoding and drain-length helper.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package systolic_pkg;

  localparam int SYS_N      = 4;
  localparam int SYS_D_W    = 8;
  localparam int SYS_ADDR_W = 8;
  localparam int SYS_K_W    = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_LOAD  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Zero vectors needed for the last operand to cross the skewed array.
  function automatic int drain_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/systolic_feed_ctrl_if.sv
// ============================================================================
// systolic_feed_ctrl_if
// Scheduler, operand-memory and skew-buffer signals of the feed controller.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface systolic_feed_ctrl_if
  import systolic_pkg::*;
#(
  parameter int N      = SYS_N,
  parameter int D_W    = SYS_D_W,
  parameter int ADDR_W = SYS_ADDR_W,
  parameter int K_W    = SYS_K_W
);

  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [K_W-1:0]    k_len;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N*D_W-1:0]  rd_data_a;
  logic [N*D_W-1:0]  rd_data_b;
  logic [N*D_W-1:0]  feed_a;
  logic [N*D_W-1:0]  feed_b;
  logic              feed_en;
  logic              acc_clear;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, base_addr, k_len, rd_data_a, rd_data_b,
    output rd_en, rd_addr, feed_a, feed_b, feed_en, acc_clear, busy, done
  );

  modport slave (
    output start, abort, base_addr, k_len, rd_data_a, rd_data_b,
    input  rd_en, rd_addr, feed_a, feed_b, feed_en, acc_clear, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/systolic_feed_ctrl_feed_counter.sv
// ============================================================================
// feed_counter
// Loadable down-counter that saturates at zero and flags the zero count.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module feed_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/systolic_feed_ctrl.sv
// ============================================================================
// systolic_feed_ctrl
// Clears the PE grid, streams k operand rows into the skew buffers, then drains.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module systolic_feed_ctrl
  import systolic_pkg::*;
#(
  parameter int N      = SYS_N,
  parameter int D_W    = SYS_D_W,
  parameter int ADDR_W = SYS_ADDR_W,
  parameter int K_W    = SYS_K_W
) (
  input  logic                 clk,
  input  logic                 reset,
  systolic_feed_ctrl_if.master bus
);

  localparam int C_ROW_W = N * D_W;
  localparam int C_DRAIN = drain_cycles(N);
  localparam int C_CNT_W = $clog2(C_DRAIN + 1);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_base;
  logic [K_W-1:0]    r_k;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_rd_en;
  logic              r_rd_en_d;
  logic              r_feed_en;
  logic              r_acc_clear;
  logic              r_busy;
  logic              r_done;
  logic              w_load_zero;
  logic              w_drain_zero;

  // Load counter holds reads remaining after the current one.
  feed_counter #(.W(K_W)) u_load_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_load     (r_state == ST_CLEAR),
    .i_load_val (r_k - K_W'(1)),
    .i_dec      (r_state == ST_LOAD),
    .o_zero     (w_load_zero)
  );

  // DRAIN spans one settle cycle for the last read return plus C_DRAIN zero cycles.
  feed_counter #(.W(C_CNT_W)) u_drain_cnt (
    .clk        (clk),
    .rst        (reset),
    .i_load     (r_state == ST_LOAD),
    .i_load_val (C_CNT_W'(C_DRAIN)),
    .i_dec      (r_state == ST_DRAIN),
    .o_zero     (w_drain_zero)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start && !bus.abort) w_next = ST_CLEAR;
      ST_CLEAR: w_next = (r_k == '0) ? ST_DONE : ST_LOAD;
      ST_LOAD:  if (w_load_zero) w_next = ST_DRAIN;
      ST_DRAIN: if (w_drain_zero) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if ((r_state != ST_IDLE) && bus.abort) begin
      w_next = ST_IDLE;
    end
  end

  // Outputs are registered from the next-state decode so they track r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_k         <= '0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_rd_en_d   <= 1'b0;
      r_feed_en   <= 1'b0;
      r_acc_clear <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && (w_next == ST_CLEAR)) begin
        r_base <= bus.base_addr;
        r_k    <= bus.k_len;
      end
      if (w_next == ST_LOAD) begin
        r_rd_addr <= (r_state == ST_LOAD) ? r_rd_addr + ADDR_W'(1) : r_base;
      end
      r_rd_en     <= (w_next == ST_LOAD);
      r_rd_en_d   <= r_rd_en && (w_next != ST_IDLE);
      r_feed_en   <= (r_rd_en && (w_next != ST_IDLE)) ||
                     ((r_state == ST_DRAIN) && (w_next == ST_DRAIN));
      r_acc_clear <= (w_next == ST_CLEAR);
      r_busy      <= (w_next != ST_IDLE);
      r_done      <= (w_next == ST_DONE);
    end
  end

  assign bus.rd_en     = r_rd_en;
  assign bus.rd_addr   = r_rd_addr;
  assign bus.feed_en   = r_feed_en;
  assign bus.acc_clear = r_acc_clear;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.feed_a    = r_rd_en_d ? bus.rd_data_a : {C_ROW_W{1'b0}};
  assign bus.feed_b    = r_rd_en_d ? bus.rd_data_b : {C_ROW_W{1'b0}};

endmodule

`default_nettype wire

// File: tb/tb_systolic_feed_ctrl.sv
// ============================================================================
// tb_systolic_feed_ctrl
// Directed and random jobs checked cycle by cycle against a timing-formula model.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_systolic_feed_ctrl;

  localparam int N      = 4;
  localparam int D_W    = 8;
  localparam int ADDR_W = 8;
  localparam int K_W    = 8;
  localparam int D      = 2 * N - 1;
  localparam int ROW_W  = N * D_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  systolic_feed_ctrl_if #(.N(N), .D_W(D_W), .ADDR_W(ADDR_W), .K_W(K_W)) bus ();

  systolic_feed_ctrl #(.N(N), .D_W(D_W), .ADDR_W(ADDR_W), .K_W(K_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [ROW_W-1:0] mem_a [256];
  logic [ROW_W-1:0] mem_b [256];

  // Operand memories: one-cycle read latency, garbage whenever not read.
  always @(posedge clk) begin
    bus.rd_data_a <= bus.rd_en ? mem_a[bus.rd_addr] : ROW_W'($urandom());
    bus.rd_data_b <= bus.rd_en ? mem_b[bus.rd_addr] : ROW_W'($urandom());
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit         active = 1'b0;
  int         t0     = 0;
  int         jk     = 0;
  int         jend   = 0;
  logic [7:0] jbase  = '0;

  function automatic int done_off(input int k);
    return (k == 0) ? 2 : k + 3 + D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int c;
    bit on;
    logic e_busy, e_done, e_clr, e_rd, e_fe;
    logic [7:0] e_addr;
    logic [ROW_W-1:0] e_a, e_b;
    c = cyc - t0;
    on = active && (c >= 1) && (c <= jend);
    e_busy = on;
    e_done = on && (c == done_off(jk));
    e_clr  = on && (c == 1);
    e_rd   = on && (c >= 2) && (c <= jk + 1);
    e_fe   = on && (jk > 0) && (c >= 3) && (c <= jk + 2 + D);
    e_addr = 8'(int'(jbase) + c - 2);
    e_a = '0;
    e_b = '0;
    if (on && (c >= 3) && (c <= jk + 2)) begin
      e_a = mem_a[8'(int'(jbase) + c - 3)];
      e_b = mem_b[8'(int'(jbase) + c - 3)];
    end
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("done", 64'(bus.done), 64'(e_done));
    chk("acc_clear", 64'(bus.acc_clear), 64'(e_clr));
    chk("rd_en", 64'(bus.rd_en), 64'(e_rd));
    chk("feed_en", 64'(bus.feed_en), 64'(e_fe));
    chk("feed_a", 64'(bus.feed_a), 64'(e_a));
    chk("feed_b", 64'(bus.feed_b), 64'(e_b));
    if (e_rd) chk("rd_addr", 64'(bus.rd_addr), 64'(e_addr));
  endtask

  // Drive one cycle of inputs, update the job model, then check after the edge.
  task automatic step(input bit st, input bit ab, input logic [7:0] b, input int k);
    int c;
    bit idle;
    bus.start     = st;
    bus.abort     = ab;
    bus.base_addr = b;
    bus.k_len     = 8'(k);
    c = cyc - t0;
    if (active && ab && (c >= 1) && (c <= jend)) jend = c;
    idle = !active || (c > jend);
    if (!reset && st && !ab && idle) begin
      active = 1'b1;
      t0     = cyc;
      jk     = k;
      jbase  = b;
      jend   = done_off(k);
    end
    @(posedge clk);
    #1;
    cyc++;
    check_cycle();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 0);
  endtask

  initial begin
    int k2, e, ab_at;
    logic [7:0] b2;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.base_addr = '0;
    bus.k_len     = '0;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = ROW_W'($urandom());
      mem_b[i] = ROW_W'($urandom());
    end

    idle_steps(3);
    #2 reset = 1'b0;
    idle_steps(2);

    // Reference job: rows {i+4,i+3,i+2,i+1} at 0x10.
    for (int i = 0; i < 4; i++) mem_a[8'h10 + i] = {8'(i + 4), 8'(i + 3), 8'(i + 2), 8'(i + 1)};
    step(1'b1, 1'b0, 8'h10, 4);
    idle_steps(17);

    step(1'b1, 1'b0, 8'h33, 0);
    idle_steps(4);

    step(1'b1, 1'b0, 8'hFE, 4);
    idle_steps(17);

    // Abort in cycle 5 of a k=8 job, restart in cycle 7.
    step(1'b1, 1'b0, 8'h40, 8);
    idle_steps(4);
    step(1'b0, 1'b1, 8'h00, 0);
    idle_steps(1);
    step(1'b1, 1'b0, 8'h80, 5);
    idle_steps(done_off(5) + 3);

    // Start pulses mid-job ignored; start right after done accepted.
    step(1'b1, 1'b0, 8'h20, 3);
    e = done_off(3);
    for (int c = 1; c <= e + 1; c++) begin
      step((c == 1) || (c == 4) || (c == e) || (c == e + 1), 1'b0, 8'h90, (c == e + 1) ? 2 : 7);
    end
    idle_steps(done_off(2) + 3);

    // Random jobs with optional abort and start noise.
    for (int j = 0; j < 8; j++) begin
      k2 = $urandom_range(0, 12);
      b2 = 8'($urandom());
      step(1'b1, 1'b0, b2, k2);
      e = done_off(k2);
      ab_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, e + 1) : -1;
      for (int c = 1; c <= e + 2; c++) begin
        step($urandom_range(0, 7) == 0, c == ab_at, 8'($urandom()), $urandom_range(0, 12));
      end
      idle_steps(25);
    end

    // Asynchronous reset in the middle of DRAIN.
    step(1'b1, 1'b0, 8'h55, 3);
    idle_steps(3 + 5);
    chk("pre_reset_feed_en", 64'(bus.feed_en), 64'(1));
    #3 reset = 1'b1;
    #1;
    chk("async_busy", 64'(bus.busy), 64'(0));
    chk("async_feed_en", 64'(bus.feed_en), 64'(0));
    chk("async_rd_en", 64'(bus.rd_en), 64'(0));
    chk("async_done", 64'(bus.done), 64'(0));
    chk("async_feed_a", 64'(bus.feed_a), 64'(0));
    active = 1'b0;
    idle_steps(2);
    #2 reset = 1'b0;
    idle_steps(20);
    step(1'b1, 1'b0, 8'h07, 2);
    idle_steps(done_off(2) + 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
